// File: rtl/interval_meter.sv
// Interval meter: counts whole ticks of TICK_US microseconds between a start
// and a stop event, saturating at all-ones with an overflow flag.
module interval_meter #(
  parameter int unsigned CLKFREQ_MHZ = 100,
  parameter int unsigned TICK_US     = 1000,
  parameter int unsigned CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic [CW-1:0] count,
  output logic          valid,
  output logic          busy,
  output logic          ovf
);

  localparam int unsigned TICK_CYCLES = CLKFREQ_MHZ * TICK_US;
  localparam int unsigned PW          = $clog2(TICK_CYCLES);

  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("interval_meter: TICK_CYCLES must be at least 2");
  end

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [CW-1:0] count_nx;
  logic          ovf_nx;
  logic          tick_c;

  // State, prescaler and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      pre   <= pre_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
    end
  end

  // Next-state and datapath update; start always restarts from a clean slate
  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    count_nx = count;
    ovf_nx   = ovf;
    tick_c   = (pre == PRE_LAST);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          pre_nx   = '0;
          count_nx = '0;
          ovf_nx   = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          pre_nx   = '0;
          count_nx = '0;
          ovf_nx   = 1'b0;
        end else begin
          // The stop edge still advances the prescaler and may land a tick
          if (tick_c) begin
            pre_nx = '0;
            if (count == CNT_MAX) begin
              ovf_nx = 1'b1;
            end else begin
              count_nx = count + CW'(1);
            end
          end else begin
            pre_nx = pre + PW'(1);
          end
          if (stop) begin
            state_nx = DONE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign valid = (state == DONE);
  assign busy  = (state == RUN);

endmodule

// File: tb/tb_interval_meter.sv
// Self-checking bench for interval_meter: a small instance (4-cycle tick, 3-bit
// count) for directed cases and a 100-cycle-tick, 16-bit instance for width.
module tb_interval_meter;

  typedef struct packed {
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, stop, start2, stop2;
  logic [2:0]  count;
  logic        valid, busy, ovf;
  logic [15:0] count2;
  logic        valid2, busy2, ovf2;

  exp_t sb[$];
  exp_t sb2[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  interval_meter #(.CLKFREQ_MHZ(1), .TICK_US(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .count(count), .valid(valid), .busy(busy), .ovf(ovf)
  );

  interval_meter #(.CLKFREQ_MHZ(10), .TICK_US(10), .CW(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2),
    .count(count2), .valid(valid2), .busy(busy2), .ovf(ovf2)
  );

  // Reference: whole ticks in n cycles, saturating at 2^cw-1
  function automatic exp_t model(input int n, input int tc, input int cw);
    exp_t e;
    int t, mx;
    t = n / tc;
    mx = (1 << cw) - 1;
    e.cnt = 16'((t > mx) ? mx : t);
    e.ovf = (t > mx);
    return e;
  endfunction

  task automatic collect(input string name);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!seen || sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no result, valid=%b queued=%0d, required valid=1 with a queued result",
               name, valid, sb.size());
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if ({16'(count), ovf} !== {e.cnt, e.ovf}) begin
        miscompares++;
        $display("FAIL %s: count=%0d ovf=%b, required count=%0d ovf=%b",
                 name, count, ovf, e.cnt, e.ovf);
      end
    end
  endtask

  // start at E0, stop at E0+n, checking the running count every cycle
  task automatic measure(input int n);
    exp_t r;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      r = model(k, 4, 3);
      vectors++;
      if ({busy, valid, ovf, count} !== {1'b1, 1'b0, r.ovf, r.cnt[2:0]}) begin
        miscompares++;
        $display("FAIL run_n%0d_k%0d: busy=%b valid=%b ovf=%b count=%0d, required 1 0 %b %0d",
                 n, k, busy, valid, ovf, count, r.ovf, r.cnt);
      end
    end
    stop = 1'b1;
    sb.push_back(model(n, 4, 3));
    @(negedge clk); stop = 1'b0;
    vectors++;
    if ({busy, valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL stop_timing_n%0d: busy=%b valid=%b, required busy=0 valid=1", n, busy, valid);
    end
    collect($sformatf("result_n%0d", n));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({count, valid, busy, ovf} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_held: count=%0d valid=%b busy=%b ovf=%b, required all 0",
                 count, valid, busy, ovf);
      end
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({count, valid, busy, ovf, count2, valid2, busy2, ovf2} !== 25'b0) begin
      miscompares++;
      $display("FAIL reset_release: count=%0d valid=%b busy=%b ovf=%b count2=%0d, required all 0",
               count, valid, busy, ovf, count2);
    end
  endtask

  task automatic test_basic();
    measure(10);
    measure(3);
    measure(4);
  endtask

  task automatic test_saturation();
    measure(40);
    measure(3);
  endtask

  task automatic test_ignored_and_simultaneous();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (2) begin
      vectors++;
      if ({busy, valid, count} !== 5'b0) begin
        miscompares++;
        $display("FAIL stop_in_idle: busy=%b valid=%b count=%0d, required 0 0 0", busy, valid, count);
      end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy, count} !== {1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL pre_restart: busy=%b count=%0d, required busy=1 count=1", busy, count);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    vectors++;
    if ({busy, valid, count} !== {1'b1, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL start_beats_stop: busy=%b valid=%b count=%0d, required 1 0 0", busy, valid, count);
    end
    repeat (5) @(negedge clk);
    stop = 1'b1;
    sb.push_back(model(6, 4, 3));
    @(negedge clk);
    collect("after_restart");
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({valid, busy, count} !== {1'b1, 1'b0, 3'd1}) begin
        miscompares++;
        $display("FAIL stop_in_done: valid=%b busy=%b count=%0d, required 1 0 1", valid, busy, count);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++;
    if ({count, valid, busy, ovf} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid: count=%0d valid=%b busy=%b ovf=%b, required all 0",
               count, valid, busy, ovf);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (3) begin
      vectors++;
      if ({valid, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL stop_after_reset: valid=%b busy=%b, required 0 0", valid, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_held_start();
    start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if ({busy, valid, count} !== {1'b1, 1'b0, 3'd0}) begin
        miscompares++;
        $display("FAIL held_start: busy=%b valid=%b count=%0d, required 1 0 0", busy, valid, count);
      end
    end
    start = 1'b0; stop = 1'b1;
    sb.push_back(model(1, 4, 3));
    @(negedge clk); stop = 1'b0;
    collect("held_start_result");
  endtask

  task automatic test_back_to_back();
    measure(5);
    measure(8);
  endtask

  task automatic measure_wide(input int n);
    exp_t r, e;
    bit seen;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      if (k % 50 == 0 || k == 99) begin
        r = model(k, 100, 16);
        vectors++;
        if ({busy2, count2} !== {1'b1, r.cnt}) begin
          miscompares++;
          $display("FAIL wide_run_k%0d: busy2=%b count2=%0d, required 1 %0d", k, busy2, count2, r.cnt);
        end
      end
    end
    stop2 = 1'b1;
    sb2.push_back(model(n, 100, 16));
    @(negedge clk); stop2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid2 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    e = sb2.pop_front();
    vectors++;
    if (!seen || {count2, ovf2} !== {e.cnt, e.ovf}) begin
      miscompares++;
      $display("FAIL wide_n%0d: valid2=%b count2=%0d ovf2=%b, required valid2=1 count2=%0d ovf2=%b",
               n, valid2, count2, ovf2, e.cnt, e.ovf);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_ignored_and_simultaneous();
    test_reset_mid();
    test_held_start();
    test_back_to_back();
    measure_wide(250);
    measure_wide(199);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
